// File: rtl/hci_wide_arbiter_pkg.sv
// Shared geometry defaults, FSM state type and width helper for the HCI wide arbiter.
package hci_package;
   localparam int unsigned DEFAULT_DW = 64;
   localparam int unsigned DEFAULT_AW = 32;
   localparam int unsigned DEFAULT_BW = 8;
   localparam int unsigned DEFAULT_WW = 32;
   localparam int unsigned DEFAULT_UW = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } hci_arb_state_t;

   // Index width that stays at least one bit wide for single-initiator builds.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/hci_core_intf.sv
// Minimal HCI core request/response bundle shared by initiators and the arbiter output.
interface hci_core_intf #(
   parameter int unsigned DW = hci_package::DEFAULT_DW,
   parameter int unsigned AW = hci_package::DEFAULT_AW,
   parameter int unsigned BW = hci_package::DEFAULT_BW,
   parameter int unsigned UW = hci_package::DEFAULT_UW
) ();
   logic          req;
   logic          gnt;
   logic [AW-1:0] add;
   logic          wen;
   logic [DW-1:0] data;
   logic [BW-1:0] be;
   logic [UW-1:0] user;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic [UW-1:0] r_user;

   modport master (output req, add, wen, data, be, user, input gnt, r_data, r_valid, r_user);
   modport slave  (input req, add, wen, data, be, user, output gnt, r_data, r_valid, r_user);
endinterface

// File: rtl/hci_wide_arbiter_rr_pick.sv
// Rotating-priority pick: first requesting index at or above i_ptr, wrapping modulo N.
module hci_rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);
   logic [IW:0]   w_sum;
   logic [IW-1:0] w_idx;

   // Walk offsets from farthest to nearest so the nearest requester overwrites last.
   always_comb begin
      o_idx   = i_ptr;
      o_valid = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         w_sum = {1'b0, i_ptr} + (IW+1)'(i);
         w_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
         if (i_req[w_idx]) begin
            o_idx   = w_idx;
            o_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/hci_wide_arbiter.sv
// Round-robin arbiter merging NB_REQ wide HCI initiators onto one port, with stall
// locking, a stall watchdog flag and fixed one-cycle response routing.
module hci_wide_arbiter
   import hci_package::*;
#(
   parameter int unsigned NB_REQ    = 4,
   parameter int unsigned DW        = DEFAULT_DW,
   parameter int unsigned AW        = DEFAULT_AW,
   parameter int unsigned BW        = DEFAULT_BW,
   parameter int unsigned WW        = DEFAULT_WW,
   parameter int unsigned OW        = DEFAULT_AW,
   parameter int unsigned UW        = DEFAULT_UW,
   parameter int unsigned MAX_STALL = 15
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   hci_core_intf.slave              in [NB_REQ-1:0],
   hci_core_intf.master             out,
   output logic                     stall_o,
   output logic [idx_w(NB_REQ)-1:0] grant_id_o
);
   localparam int unsigned IW = idx_w(NB_REQ);
   localparam int unsigned CW = $clog2(MAX_STALL + 1);

   hci_arb_state_t            r_state, w_state_n;
   logic [IW-1:0]             r_rr, r_lock_id, r_id, w_pick, w_winner, w_rr_n;
   logic [CW-1:0]             r_stall_cnt;
   logic                      r_gnt;
   logic                      w_pick_vld, w_active, w_locked, w_granted, w_stalled, w_to_idle;
   logic                      w_unused;
   logic [NB_REQ-1:0]         w_req, w_wen;
   logic [NB_REQ-1:0][AW-1:0] w_add;
   logic [NB_REQ-1:0][DW-1:0] w_data;
   logic [NB_REQ-1:0][BW-1:0] w_be;
   logic [NB_REQ-1:0][UW-1:0] w_user;

   for (genvar g = 0; g < NB_REQ; g++) begin : g_port
      assign w_req[g]        = in[g].req;
      assign w_wen[g]        = in[g].wen;
      assign w_add[g]        = in[g].add;
      assign w_data[g]       = in[g].data;
      assign w_be[g]         = in[g].be;
      assign w_user[g]       = in[g].user;
      assign in[g].gnt       = w_granted & (w_winner == IW'(g));
      assign in[g].r_valid   = w_active & out.r_valid & r_gnt & (r_id == IW'(g));
      assign in[g].r_data    = out.r_data;
      assign in[g].r_user    = '0;
   end

   hci_rr_pick #(.N(NB_REQ), .IW(IW)) u_pick (
      .i_req   (w_req),
      .i_ptr   (r_rr),
      .o_idx   (w_pick),
      .o_valid (w_pick_vld)
   );

   assign w_active  = rst_ni & ~clear_i;
   // A withdrawn lock owner falls straight back to round-robin in the same cycle.
   assign w_locked  = w_active & (r_state == LOCKED) & w_req[r_lock_id];
   assign w_winner  = w_locked ? r_lock_id : w_pick;
   assign w_granted = out.gnt & out.req;
   assign w_stalled = out.req & ~out.gnt;
   assign w_rr_n    = (w_winner == IW'(NB_REQ - 1)) ? '0 : w_winner + 1'b1;

   assign out.req    = |w_req;
   assign out.wen    = w_wen[w_winner];
   assign out.add    = w_add[w_winner];
   assign out.data   = w_data[w_winner];
   assign out.be     = w_be[w_winner];
   assign out.user   = w_user[w_winner];
   assign grant_id_o = w_winner;
   assign stall_o    = w_active & (r_stall_cnt >= CW'(MAX_STALL));
   assign w_unused   = ^{out.r_user, w_pick_vld, 1'(WW), 1'(OW)};

   always_comb begin
      w_state_n = r_state;
      w_to_idle = 1'b0;
      case (r_state)
         IDLE:   if (w_stalled) w_state_n = LOCKED;
         LOCKED: if (out.gnt || !w_req[r_lock_id]) begin
            w_state_n = IDLE;
            w_to_idle = 1'b1;
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_state     <= IDLE;
         r_rr        <= '0;
         r_lock_id   <= '0;
         r_stall_cnt <= '0;
         r_gnt       <= 1'b0;
         r_id        <= '0;
      end else begin
         r_state <= w_state_n;
         r_gnt   <= w_granted;
         r_id    <= w_winner;
         if (w_granted) r_rr <= w_rr_n;
         if (r_state == IDLE && w_stalled) r_lock_id <= w_winner;
         if (w_granted || w_to_idle) r_stall_cnt <= '0;
         else if (w_stalled && r_stall_cnt < CW'(MAX_STALL)) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_hci_wide_arbiter.sv
// Scenario and randomized checks of hci_wide_arbiter against a cycle-level behavioural model.
module tb_hci_wide_arbiter;
   localparam int unsigned NB = 4, DW = 64, AW = 32, BW = 8, UW = 2, MS = 4;

   logic clk = 1'b0;
   logic rst_n, clear;
   always #5 clk = ~clk;

   logic [NB-1:0]         t_req;
   logic [NB-1:0][AW-1:0] t_add;
   logic [NB-1:0][DW-1:0] t_data;
   logic                  t_gnt, t_rvalid;
   logic [DW-1:0]         t_rdata;
   logic [NB-1:0]         o_gnt, o_rvalid;
   logic [NB-1:0][DW-1:0] o_rdata;
   logic [NB-1:0][UW-1:0] o_ruser;
   logic                  stall;
   logic [1:0]            gid;

   hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .UW(UW)) w_in [NB-1:0] ();
   hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .UW(UW)) w_out ();

   for (genvar g = 0; g < NB; g++) begin : g_tb
      assign w_in[g].req  = t_req[g];
      assign w_in[g].add  = t_add[g];
      assign w_in[g].data = t_data[g];
      assign w_in[g].wen  = t_data[g][DW-1];
      assign w_in[g].be   = t_data[g][BW-1:0];
      assign w_in[g].user = UW'(g);
      assign o_gnt[g]     = w_in[g].gnt;
      assign o_rvalid[g]  = w_in[g].r_valid;
      assign o_rdata[g]   = w_in[g].r_data;
      assign o_ruser[g]   = w_in[g].r_user;
   end
   assign w_out.gnt     = t_gnt;
   assign w_out.r_valid = t_rvalid;
   assign w_out.r_data  = t_rdata;
   assign w_out.r_user  = '0;

   hci_wide_arbiter #(.NB_REQ(NB), .DW(DW), .AW(AW), .BW(BW), .WW(32), .OW(AW), .UW(UW),
                      .MAX_STALL(MS)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in(w_in), .out(w_out),
      .stall_o(stall), .grant_id_o(gid));

   int total = 0, bad = 0;
   // model state
   int m_rr, m_lock, m_cnt, m_idq;
   bit m_locked, m_gq;
   // expectations for the current cycle
   int e_win;
   logic [NB-1:0] e_gnt, e_rv;
   logic e_stall, e_oreq;

   function automatic int pick(input logic [NB-1:0] r, input int p);
      int k;
      for (int i = 0; i < NB; i++) begin
         k = (p + i) % NB;
         if (r[k[1:0]]) return k;
      end
      return p;
   endfunction

   task automatic eval();
      bit act;
      #1;
      act = rst_n && !clear;
      if (act && m_locked && t_req[m_lock[1:0]]) e_win = m_lock;
      else e_win = pick(t_req, m_rr);
      e_oreq  = |t_req;
      e_gnt   = (t_gnt && e_oreq) ? (NB'(1) << e_win) : '0;
      e_rv    = (act && t_rvalid && m_gq) ? (NB'(1) << m_idq) : '0;
      e_stall = act && (m_cnt >= MS);
   endtask

   task automatic adv();
      bit granted, to_idle;
      @(posedge clk);
      if (!rst_n || clear) begin
         m_rr = 0; m_locked = 0; m_lock = 0; m_cnt = 0; m_gq = 0; m_idq = 0;
      end else begin
         granted = t_gnt && (|t_req);
         to_idle = m_locked && (t_gnt || !t_req[m_lock[1:0]]);
         if (granted || to_idle) m_cnt = 0;
         else if ((|t_req) && !t_gnt && m_cnt < MS) m_cnt++;
         if (!m_locked && (|t_req) && !t_gnt) begin m_locked = 1; m_lock = e_win; end
         else if (to_idle) m_locked = 0;
         m_gq = granted;
         m_idq = e_win;
         if (granted) m_rr = (e_win + 1) % NB;
      end
      @(negedge clk);
   endtask

   task automatic step();
      eval();
      adv();
   endtask

   task automatic do_reset();
      rst_n = 0; clear = 0; t_req = '0; t_gnt = 0; t_rvalid = 0;
      step();
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; clear = 0; t_req = 4'b0110; t_gnt = 1; t_rvalid = 1;
      step(); step();
      eval();
      total++;
      if (gid !== 2'd1 || stall !== 1'b0 || o_rvalid !== '0) begin
         bad++; $display("FAIL reset_hold got id=%0d stall=%b rv=%b want id=1 stall=0 rv=0", gid, stall, o_rvalid);
      end
      adv();
      rst_n = 1; t_gnt = 0;
      eval();
      total++;
      if (gid !== 2'd1 || o_gnt !== '0 || stall !== 1'b0 || o_rvalid !== '0) begin
         bad++; $display("FAIL reset_release got id=%0d gnt=%b stall=%b rv=%b want id=1 gnt=0 stall=0 rv=0",
                         gid, o_gnt, stall, o_rvalid);
      end
      adv();
   endtask

   task automatic test_round_robin();
      int seq [5];
      seq = '{0, 1, 2, 3, 0};
      do_reset();
      t_req = '1; t_gnt = 1; t_rvalid = 1;
      for (int c = 0; c < 6; c++) begin
         eval();
         if (c < 5) begin
            total++;
            if (gid !== 2'(seq[c]) || o_gnt !== (NB'(1) << seq[c])) begin
               bad++; $display("FAIL rr_grant c=%0d got id=%0d gnt=%b want id=%0d", c, gid, o_gnt, seq[c]);
            end
         end
         if (c > 0) begin
            total++;
            if (o_rvalid !== (NB'(1) << seq[c-1])) begin
               bad++; $display("FAIL rr_rvalid c=%0d got %b want %b", c, o_rvalid, NB'(1) << seq[c-1]);
            end
         end
         adv();
      end
   endtask

   task automatic test_lock();
      do_reset();
      t_req = 4'b0101; t_gnt = 0;
      for (int c = 0; c < 3; c++) begin
         eval();
         total++;
         if (gid !== 2'd0 || o_gnt !== '0) begin
            bad++; $display("FAIL lock_hold c=%0d got id=%0d gnt=%b want id=0 gnt=0000", c, gid, o_gnt);
         end
         adv();
      end
      t_gnt = 1;
      eval();
      total++;
      if (o_gnt !== 4'b0001) begin bad++; $display("FAIL lock_release got gnt=%b want 0001", o_gnt); end
      adv();
      eval();
      total++;
      if (gid !== 2'd2 || o_gnt !== 4'b0100) begin
         bad++; $display("FAIL lock_next got id=%0d gnt=%b want id=2 gnt=0100", gid, o_gnt);
      end
      adv();
      // pointer now 3: lock on 0, then 3 arrives and would win by rotation
      t_req = 4'b0001; t_gnt = 0;
      step();
      t_req = 4'b1001;
      eval();
      total++;
      if (gid !== 2'd0 || o_gnt !== '0) begin
         bad++; $display("FAIL lock_override got id=%0d gnt=%b want id=0 gnt=0000", gid, o_gnt);
      end
      adv();
      t_gnt = 1;
      eval();
      total++;
      if (o_gnt !== 4'b0001) begin bad++; $display("FAIL lock_override_gnt got %b want 0001", o_gnt); end
      adv();
   endtask

   task automatic test_stall();
      do_reset();
      t_req = 4'b0010; t_gnt = 0;
      for (int c = 0; c < 7; c++) begin
         eval();
         total++;
         if (stall !== (c >= 4)) begin bad++; $display("FAIL stall_rise c=%0d got %b want %b", c, stall, c >= 4); end
         adv();
      end
      t_gnt = 1;
      eval();
      total++;
      if (stall !== 1'b1 || o_gnt !== 4'b0010) begin
         bad++; $display("FAIL stall_grant got stall=%b gnt=%b want stall=1 gnt=0010", stall, o_gnt);
      end
      adv();
      t_gnt = 0; t_req = '0;
      eval();
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL stall_fall got %b want 0", stall); end
      adv();
   endtask

   task automatic test_withdrawal();
      do_reset();
      t_req = 4'b0010; t_gnt = 0;
      step();
      t_req = 4'b1000;
      eval();
      total++;
      if (gid !== 2'd3 || o_gnt !== '0) begin
         bad++; $display("FAIL withdraw_same got id=%0d gnt=%b want id=3 gnt=0000", gid, o_gnt);
      end
      adv();
      t_req = 4'b1001;
      eval();
      total++;
      if (gid !== 2'd0) begin bad++; $display("FAIL withdraw_idle got id=%0d want 0", gid); end
      adv();
      t_gnt = 1;
      eval();
      total++;
      if (o_gnt !== 4'b0001) begin bad++; $display("FAIL withdraw_gnt got %b want 0001", o_gnt); end
      adv();
   endtask

   task automatic test_clear_grant();
      do_reset();
      t_req = 4'b0001; t_gnt = 1;
      step();
      t_req = 4'b0100; clear = 1; t_rvalid = 1;
      eval();
      total++;
      if (o_gnt !== 4'b0100 || o_rvalid !== '0) begin
         bad++; $display("FAIL clear_grant got gnt=%b rv=%b want gnt=0100 rv=0000", o_gnt, o_rvalid);
      end
      adv();
      clear = 0; t_req = '0;
      eval();
      total++;
      if (o_rvalid !== '0) begin bad++; $display("FAIL clear_rvalid got %b want 0000", o_rvalid); end
      adv();
      t_req = '1; t_gnt = 0; t_rvalid = 0;
      eval();
      total++;
      if (gid !== 2'd0) begin bad++; $display("FAIL clear_rr got id=%0d want 0", gid); end
      adv();
   endtask

   task automatic test_response_routing();
      do_reset();
      t_req = 4'b1000; t_gnt = 1;
      step();
      t_req = '0; t_rvalid = 1; t_rdata = 64'hDEAD_BEEF_CAFE_F00D;
      eval();
      total++;
      if (o_rvalid !== 4'b1000 || o_rdata[3] !== 64'hDEAD_BEEF_CAFE_F00D || o_ruser !== '0) begin
         bad++; $display("FAIL route got rv=%b data=%h ruser=%b want rv=1000 data=deadbeefcafef00d ruser=0",
                         o_rvalid, o_rdata[3], o_ruser);
      end
      adv();
      // response in flight across a reset is dropped
      t_req = 4'b0010; t_rvalid = 0;
      step();
      rst_n = 0; t_req = '0; t_rvalid = 1;
      eval();
      total++;
      if (o_rvalid !== '0) begin bad++; $display("FAIL reset_inflight got %b want 0000", o_rvalid); end
      adv();
      rst_n = 1;
      eval();
      total++;
      if (o_rvalid !== '0) begin bad++; $display("FAIL reset_after got %b want 0000", o_rvalid); end
      adv();
      t_rvalid = 0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) t_req = NB'($urandom);
         t_gnt    = ($urandom_range(0, 1) == 0);
         t_rvalid = ($urandom_range(0, 3) != 0);
         t_rdata  = {$urandom, $urandom};
         clear    = ($urandom_range(0, 39) == 0);
         rst_n    = ($urandom_range(0, 99) != 0);
         for (int k = 0; k < NB; k++) begin
            t_add[k]  = $urandom;
            t_data[k] = {$urandom, $urandom};
         end
         eval();
         total++;
         if ({w_out.req, o_gnt, o_rvalid, stall, gid} !== {e_oreq, e_gnt, e_rv, e_stall, 2'(e_win)}) begin
            bad++;
            $display("FAIL rand_ctrl c=%0d got req=%b gnt=%b rv=%b stall=%b id=%0d want req=%b gnt=%b rv=%b stall=%b id=%0d",
                     c, w_out.req, o_gnt, o_rvalid, stall, gid, e_oreq, e_gnt, e_rv, e_stall, e_win);
         end
         total++;
         if ({w_out.add, w_out.data, w_out.be, w_out.user, o_rdata} !==
             {t_add[e_win[1:0]], t_data[e_win[1:0]], t_data[e_win[1:0]][BW-1:0], UW'(e_win), {NB{t_rdata}}}) begin
            bad++;
            $display("FAIL rand_data c=%0d got add=%h data=%h user=%0d want add=%h data=%h user=%0d",
                     c, w_out.add, w_out.data, w_out.user, t_add[e_win[1:0]], t_data[e_win[1:0]], e_win);
         end
         adv();
      end
      rst_n = 1; clear = 0;
   endtask

   initial begin
      rst_n = 0; clear = 0; t_req = '0; t_gnt = 0; t_rvalid = 0; t_rdata = '0;
      for (int k = 0; k < NB; k++) begin
         t_add[k]  = AW'(32'h1000 * (k + 1));
         t_data[k] = DW'(k);
      end
      m_rr = 0; m_lock = 0; m_cnt = 0; m_idq = 0; m_locked = 0; m_gq = 0;
      test_reset();
      test_round_robin();
      test_lock();
      test_stall();
      test_withdrawal();
      test_clear_grant();
      test_response_routing();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
